hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Producer side of the EX-stage operand-forwarding interface: generates forward_A/forward_B
//  and the load-use stall for the 5-stage pipeline. Keeps a shadow pipeline of destination
//  info for the EX, MEM and WB slots, which advances in lockstep with the ID/EX, EX/MEM and
//  MEM/WB registers. Forward codes are registered and line up with the instruction in EX.
// PARAMETERS
//  REG_ADDR_W  5   register-index width
//  CNT_W       16  width of the saturating stall counter
// PORTS
//  clk          in   1           pipeline clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  id_rs        in   REG_ADDR_W  rs index of the instruction in ID
//  id_rt        in   REG_ADDR_W  rt index of the instruction in ID
//  id_use_rs    in   1           ID instruction reads rs
//  id_use_rt    in   1           ID instruction reads rt (ALU operand or store data)
//  id_dst       in   REG_ADDR_W  destination register of the ID instruction
//  id_reg_write in   1           ID instruction writes the register file
//  id_mem_read  in   1           ID instruction is a load
//  flush        in   1           branch/jump taken; kill the ID instruction
//  stall        out  1           combinational; hold PC and IF/ID, insert a bubble into EX
//  forward_A    out  2           registered; 00 regfile, 01 EX/MEM result, 10 WB value
//  forward_B    out  2           registered; same encoding as forward_A
//  ex_bubble    out  1           registered; EX slot holds a bubble
//  stall_count  out  CNT_W       registered; total load-use stalls, saturates at all-ones
// BEHAVIOUR
//  - State: slots EX, MEM and WB, each holding {dst, reg_write, mem_read}.
//  - Reset: all slots get reg_write=0 and mem_read=0. forward_A=forward_B=00,
//    ex_bubble=1, stall_count=0. stall reads 0 from the first cycle after reset.
//  - hazA = id_use_rs & EX.mem_read & EX.reg_write & EX.dst!=0 & EX.dst==id_rs
//  - hazB = same as hazA, using id_use_rt and id_rt.
//  - stall = (hazA | hazB) & ~flush.
//  - Each rising edge (not in reset):
//    - WB <= MEM and MEM <= EX, always. MEM and WB never stall.
//    - If flush or stall: EX <= bubble (reg_write=0, mem_read=0, dst=0).
//      Also forward_A=forward_B=00 and ex_bubble=1.
//    - Otherwise: EX <= {id_dst, id_reg_write, id_mem_read} and ex_bubble=0.
//      Forward codes are computed from the pre-edge slots.
//  - Forward code for source s (rs or rt), given its use bit u:
//    - 01 if u & EX.reg_write & EX.dst!=0 & EX.dst==s (this producer moves into MEM).
//    - Else 10 if u & MEM.reg_write & MEM.dst!=0 & MEM.dst==s (this producer moves into WB).
//    - Else 00.
//    - EX/MEM has priority over WB. Register 0 never forwards.
//    - A slot leaving WB needs no forward; the regfile is write-before-read.
//  - A load in EX/MEM never yields code 01. The stall guarantees that the consumer reaches EX
//    only after the load is in WB, and it then gets code 10.
//  - stall_count increments on each edge where stall=1 and holds at 2^CNT_W-1.
//  - Simultaneous flush and hazard: flush wins. stall=0, a bubble is inserted, the counter is
//    unchanged.
//  - Reset mid-operation clears every slot in the same edge. There is no residual forwarding.
//  - One stall cycle per load-use pair. Because the EX slot is then a bubble, stall cannot
//    stay asserted for two consecutive cycles.
// TESTING
//  T1: add r3<-.. then add r4<-r3,r1 back-to-back -> consumer's EX cycle: forward_A=01,
//      forward_B=00, stall never 1.
//  T2: add r3, nop, add r4<-r1,r3 -> forward_B=10. Then add r3, add r3, add r5<-r3,r3 ->
//      forward_A=forward_B=01 (priority).
//  T3: lw r2, then add r5<-r2,r2 -> stall=1 exactly one cycle, ex_bubble=1 and codes 00 for
//      that EX cycle. Next EX cycle: forward_A=forward_B=10, stall_count=1.
//  T4: addi r0<-.. (reg_write=1, dst=0), then add r4<-r0,r0 -> forward_A=forward_B=00.
//      Also sw with id_use_rt=1 after add r7, rt=7 -> forward_B=01.
//  T5: lw r2 then dependent add with flush=1 in the same cycle -> stall=0, ex_bubble=1,
//      stall_count unchanged.
//  T6: pulse rst mid-stream with producers in EX and MEM -> after the edge: codes 00,
//      ex_bubble=1, stall_count=0. With CNT_W=2, four stalls -> count holds at 3.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Producer side of the EX-stage operand-forwarding interface for a 5-stage
//   pipeline. A shadow pipeline of destination info (EX, MEM, WB slots)
//   advances in lockstep with the ID/EX, EX/MEM and MEM/WB registers.
//   Forward codes are registered so they line up with the instruction in EX.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   id_rs, id_rt   source indices of the ID instruction
//   id_use_rs/rt   ID instruction actually reads rs / rt
//   id_dst         destination of the ID instruction
//   id_reg_write   ID instruction writes the register file
//   id_mem_read    ID instruction is a load
//   flush          kill the ID instruction (taken branch/jump)
//   stall          combinational load-use stall (hold PC and IF/ID, bubble EX)
//   forward_A/B    registered: 00 regfile, 01 EX/MEM result, 10 WB value
//   ex_bubble      registered: EX slot holds a bubble
//   stall_count    registered saturating count of load-use stalls
//   slot_state     debug view of the slots, {EX, MEM, WB}, each {dst, reg_write, mem_read}
//
// Handshake: there is no valid/ready pair here. stall is a hold request to the
// front end: while stall=1 the ID instruction is not consumed and must be
// presented again on the next cycle.
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [REG_ADDR_W-1:0]         id_rs,
  input  logic [REG_ADDR_W-1:0]         id_rt,
  input  logic                          id_use_rs,
  input  logic                          id_use_rt,
  input  logic [REG_ADDR_W-1:0]         id_dst,
  input  logic                          id_reg_write,
  input  logic                          id_mem_read,
  input  logic                          flush,
  output logic                          stall,
  output logic [1:0]                    forward_A,
  output logic [1:0]                    forward_B,
  output logic                          ex_bubble,
  output logic [CNT_W-1:0]              stall_count,
  output logic [3*(REG_ADDR_W+2)-1:0]   slot_state
);

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;

  logic [REG_ADDR_W-1:0] ex_dst, mem_dst, wb_dst;
  logic                  ex_rw, mem_rw, wb_rw;
  logic                  ex_mr, mem_mr, wb_mr;

  logic       haz_a, haz_b;
  logic [1:0] fwd_a_next, fwd_b_next;

  // Load in EX whose result a source of the ID instruction needs: the value
  // only exists after MEM, so one bubble is required.
  always_comb begin
    haz_a = id_use_rs & ex_mr & ex_rw & (ex_dst != REG_ZERO) & (ex_dst == id_rs);
    haz_b = id_use_rt & ex_mr & ex_rw & (ex_dst != REG_ZERO) & (ex_dst == id_rt);
    stall = (haz_a | haz_b) & ~flush;
  end

  // Forward selection from the pre-edge slots. The EX producer moves into MEM
  // at the same edge the consumer enters EX (code 01); the MEM producer moves
  // into WB (code 10). The younger producer wins. A load in EX never reaches
  // here as a 01 source because it always causes a stall first.
  always_comb begin
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (id_use_rs & ex_rw & (ex_dst != REG_ZERO) & (ex_dst == id_rs))
      fwd_a_next = 2'b01;
    else if (id_use_rs & mem_rw & (mem_dst != REG_ZERO) & (mem_dst == id_rs))
      fwd_a_next = 2'b10;
    if (id_use_rt & ex_rw & (ex_dst != REG_ZERO) & (ex_dst == id_rt))
      fwd_b_next = 2'b01;
    else if (id_use_rt & mem_rw & (mem_dst != REG_ZERO) & (mem_dst == id_rt))
      fwd_b_next = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_dst      <= '0;
      ex_rw       <= 1'b0;
      ex_mr       <= 1'b0;
      mem_dst     <= '0;
      mem_rw      <= 1'b0;
      mem_mr      <= 1'b0;
      wb_dst      <= '0;
      wb_rw       <= 1'b0;
      wb_mr       <= 1'b0;
      forward_A   <= 2'b00;
      forward_B   <= 2'b00;
      ex_bubble   <= 1'b1;
      stall_count <= '0;
    end else begin
      // MEM and WB never stall.
      wb_dst  <= mem_dst;
      wb_rw   <= mem_rw;
      wb_mr   <= mem_mr;
      mem_dst <= ex_dst;
      mem_rw  <= ex_rw;
      mem_mr  <= ex_mr;
      if (flush | stall) begin
        ex_dst    <= '0;
        ex_rw     <= 1'b0;
        ex_mr     <= 1'b0;
        forward_A <= 2'b00;
        forward_B <= 2'b00;
        ex_bubble <= 1'b1;
      end else begin
        ex_dst    <= id_dst;
        ex_rw     <= id_reg_write;
        ex_mr     <= id_mem_read;
        forward_A <= fwd_a_next;
        forward_B <= fwd_b_next;
        ex_bubble <= 1'b0;
      end
      if (stall && stall_count != CNT_MAX)
        stall_count <= stall_count + 1'b1;
    end
  end

  assign slot_state = {ex_dst, ex_rw, ex_mr, mem_dst, mem_rw, mem_mr, wb_dst, wb_rw, wb_mr};

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;

  logic        stall, ex_bubble, s_stall, s_ex_bubble;
  logic [1:0]  forward_A, forward_B, s_fa, s_fb;
  logic [15:0] stall_count;
  logic [1:0]  s_count;
  logic [20:0] slot_state, s_slot_state;

  int checks = 0;
  int passes = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .forward_A(forward_A), .forward_B(forward_B),
    .ex_bubble(ex_bubble), .stall_count(stall_count), .slot_state(slot_state)
  );

  // Narrow counter copy, same stimulus, to see saturation quickly.
  hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(s_stall), .forward_A(s_fa), .forward_B(s_fb),
    .ex_bubble(s_ex_bubble), .stall_count(s_count), .slot_state(s_slot_state)
  );

  // ---------------- reference model ----------------
  // hist[0] = instruction most recently accepted into EX, hist[1] the one
  // before it, hist[2] the one before that. Bubbles are writers of nothing.
  typedef struct packed {
    logic [4:0] dst;
    logic       rw;
    logic       mr;
  } instr_t;

  instr_t     hist[3];
  logic [1:0] m_fa, m_fb;
  logic       m_bubble;
  int         m_stalls;

  function automatic logic writes(instr_t i, logic [4:0] r);
    return i.rw && i.dst != 5'd0 && i.dst == r;
  endfunction

  function automatic logic m_stall();
    logic need;
    need = (id_use_rs && writes(hist[0], id_rs)) || (id_use_rt && writes(hist[0], id_rt));
    return need && hist[0].mr && !flush;
  endfunction

  function automatic logic [1:0] m_fwd(logic u, logic [4:0] r);
    if (!u) return 2'b00;
    if (writes(hist[0], r)) return 2'b01;
    if (writes(hist[1], r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    m_fa = 2'b00; m_fb = 2'b00; m_bubble = 1'b1; m_stalls = 0;
  endtask

  // ---------------- check ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_regs(string tag);
    logic [1:0] sat;
    sat = (m_stalls > 3) ? 2'd3 : 2'(m_stalls);
    chk({tag, "_fa"}, 32'(forward_A), 32'(m_fa));
    chk({tag, "_fb"}, 32'(forward_B), 32'(m_fb));
    chk({tag, "_bub"}, 32'(ex_bubble), 32'(m_bubble));
    chk({tag, "_cnt"}, 32'(stall_count), 32'(m_stalls));
    chk({tag, "_scnt"}, 32'(s_count), 32'(sat));
    chk({tag, "_slots"}, 32'(slot_state), 32'({hist[0], hist[1], hist[2]}));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(string tag);
    rst = 1'b1;
    @(posedge clk);
    m_reset();
    #1;
    check_regs(tag);
    rst = 1'b0;
  endtask

  // Present one ID instruction for one cycle, check stall before the edge and
  // registered outputs after it.
  task automatic step(string tag, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                      logic [4:0] dst, logic rw, logic mr, logic fl);
    logic   st;
    instr_t nxt;
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr; flush = fl;
    #2;
    st = m_stall();
    chk({tag, "_stall"}, 32'(stall), 32'(st));
    if (fl || st) begin
      nxt = '0; m_fa = 2'b00; m_fb = 2'b00; m_bubble = 1'b1;
    end else begin
      nxt = '{dst: dst, rw: rw, mr: mr};
      m_fa = m_fwd(urs, rs); m_fb = m_fwd(urt, rt); m_bubble = 1'b0;
    end
    if (st) m_stalls++;
    @(posedge clk);
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = nxt;
    #1;
    check_regs(tag);
  endtask

  task automatic nop(string tag);
    step(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m_reset();
    do_reset("rst0");
    chk("rst0_stall", 32'(stall), 32'd0);

    // T1: back-to-back ALU dependency on rs.
    step("t1_p", 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    step("t1_c", 5'd3, 5'd1, 1, 1, 5'd4, 1, 0, 0);
    chk("t1_fa_const", 32'(forward_A), 32'd1);
    chk("t1_fb_const", 32'(forward_B), 32'd0);

    // T2: one-apart dependency, then EX/MEM priority over WB.
    step("t2_p", 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    nop("t2_n");
    step("t2_c", 5'd1, 5'd3, 1, 1, 5'd4, 1, 0, 0);
    chk("t2_fb_const", 32'(forward_B), 32'd2);
    step("t2_p1", 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    step("t2_p2", 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    step("t2_c2", 5'd3, 5'd3, 1, 1, 5'd5, 1, 0, 0);
    chk("t2_fa_pri", 32'(forward_A), 32'd1);
    chk("t2_fb_pri", 32'(forward_B), 32'd1);

    // T3: load-use costs exactly one stall.
    do_reset("t3_rst");
    step("t3_lw", 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
    step("t3_s", 5'd2, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    chk("t3_bub_const", 32'(ex_bubble), 32'd1);
    step("t3_c", 5'd2, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    chk("t3_stall_once", 32'(stall), 32'd0);
    chk("t3_fa_const", 32'(forward_A), 32'd2);
    chk("t3_cnt_const", 32'(stall_count), 32'd1);

    // T4: r0 never forwards; store data via rt forwards.
    step("t4_p0", 5'd1, 5'd0, 1, 0, 5'd0, 1, 0, 0);
    step("t4_c0", 5'd0, 5'd0, 1, 1, 5'd4, 1, 0, 0);
    chk("t4_r0_fa", 32'(forward_A), 32'd0);
    step("t4_p7", 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0);
    step("t4_sw", 5'd1, 5'd7, 1, 1, 5'd0, 0, 0, 0);
    chk("t4_sw_fb", 32'(forward_B), 32'd1);

    // T5: flush wins over a load-use hazard.
    step("t5_lw", 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
    step("t5_fl", 5'd2, 5'd2, 1, 1, 5'd5, 1, 0, 1);
    chk("t5_bub_const", 32'(ex_bubble), 32'd1);

    // T6: reset mid-stream with producers in EX and MEM.
    step("t6_p1", 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    step("t6_p2", 5'd1, 5'd2, 1, 1, 5'd4, 1, 0, 0);
    do_reset("t6_rst");
    step("t6_after", 5'd3, 5'd4, 1, 1, 5'd6, 1, 0, 0);
    chk("t6_no_resid", 32'(forward_A), 32'd0);
    // Four load-use stalls: narrow counter pins at 3.
    for (int k = 0; k < 4; k++) begin
      step("t6_lw", 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
      step("t6_s", 5'd2, 5'd1, 1, 1, 5'd5, 1, 0, 0);
      step("t6_c", 5'd2, 5'd1, 1, 1, 5'd5, 1, 0, 0);
    end
    chk("t6_sat_const", 32'(s_count), 32'd3);
    chk("t6_cnt_const", 32'(stall_count), 32'd4);

    // Random traffic over a small register window to make hazards frequent.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_rst");
      end else begin
        logic rw;
        rw = 1'($urandom_range(0, 3) != 0);
        step("rnd",
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), rw,
             rw & 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 7) == 0));
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
